// File: rtl/dmem_lsu_pkg.sv
// -----------------------------------------------------------------------------
// dmem_lsu_pkg
// Shared definitions for the data-memory load/store unit:
//   - RV32I load/store funct3 codes
//   - LSU state encoding
//   - request classification helpers (legality, alignment, access width)
// -----------------------------------------------------------------------------
package dmem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_ISSUE   = 3'd2,
        S_RD_WAIT = 3'd3,
        S_WRITE   = 3'd4,
        S_RESP    = 3'd5
    } lsu_state_t;

    // Byte access (B or BU): the low two funct3 bits carry the width.
    function automatic logic is_byte(input logic [2:0] f3);
        return (f3[1:0] == 2'b00);
    endfunction

    // Halfword access (H or HU).
    function automatic logic is_half(input logic [2:0] f3);
        return (f3[1:0] == 2'b01);
    endfunction

    // Loads accept B/H/W/BU/HU; stores only B/H/W (no unsigned store forms).
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Natural alignment: halfwords on even bytes, words on multiples of four.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        if (is_half(f3)) begin
            return lo[0];
        end
        if (f3 == F3_W) begin
            return (lo != 2'b00);
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// -----------------------------------------------------------------------------
// dmem_lsu_align
// Combinational lane logic for sub-word accesses on a little-endian 32-bit word.
// Ports:
//   i_word       word read from dmem
//   i_wdata      store data (rs2); low byte/half used for SB/SH
//   i_addr_lo    byte offset within the word (addr[1:0])
//   i_funct3     RV32I width/sign code
//   o_load_data  selected lane, sign- or zero-extended (full word for LW)
//   o_merge_data i_word with the store lane(s) replaced by i_wdata
// -----------------------------------------------------------------------------
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_lane_en;
    logic [31:0] w_rep_data;

    // ---------------- extract ----------------
    always_comb begin
        w_byte = i_word[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
    end

    assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_load_data = i_word;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'd0, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'd0, w_half};
            default: o_load_data = i_word;
        endcase
    end

    // ---------------- merge ----------------
    // The store data is replicated across the word so every lane that is
    // enabled simply takes its own slice of the replicated value.
    always_comb begin
        w_lane_en  = 4'b1111;
        w_rep_data = i_wdata;
        if (is_byte(i_funct3)) begin
            w_lane_en  = 4'b0001 << i_addr_lo;
            w_rep_data = {4{i_wdata[7:0]}};
        end else if (is_half(i_funct3)) begin
            w_lane_en  = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            w_rep_data = {2{i_wdata[15:0]}};
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign o_merge_data[gi*8 +: 8] = w_lane_en[gi] ? w_rep_data[gi*8 +: 8]
                                                       : i_word[gi*8 +: 8];
    end

endmodule

// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu
// Core-side load/store initiator for the word-addressed, variable-latency dmem.
// Takes one RV32I load/store from the MEM stage, drives dmem, waits for read
// data, extracts sub-word loads and performs read-modify-write for SB/SH.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_valid/i_we/i_funct3    request strobe, store flag, width/sign code
//   i_addr/i_wdata           byte address, store data
//   o_busy                   high whenever not IDLE (stalls the core)
//   o_done/o_rdata/o_err     one-cycle completion pulse with result/error
//   o_mem_ren/o_mem_wen      one-cycle dmem read/write strobes
//   o_mem_addr/o_mem_wdata   word-aligned dmem address, full write word
//   i_mem_rvd/i_mem_rdata    dmem read-data-valid pulse and read word
// -----------------------------------------------------------------------------
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_rvd,
    input  logic [31:0] i_mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_t       r_state;
    lsu_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;

    // Latched request
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_wdata;

    // Registered outputs and their next values
    logic        r_mem_ren,   w_mem_ren_next;
    logic        r_mem_wen,   w_mem_wen_next;
    logic        r_done,      w_done_next;
    logic        r_err,       w_err_next;
    logic [31:0] r_rdata,     w_rdata_next;
    logic [31:0] r_mem_addr,  w_mem_addr_next;
    logic [31:0] r_mem_wdata, w_mem_wdata_next;

    logic        w_accept;
    logic        w_req_bad;
    logic        w_timeout;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;

    assign w_accept  = (r_state == S_IDLE) && i_valid;
    assign w_req_bad = !f3_legal(i_we, i_funct3) || f3_misaligned(i_funct3, i_addr[1:0]);
    // Last RD_WAIT cycle: r_cnt counts cycles already spent waiting.
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    dmem_lsu_align u_align (
        .i_word       (i_mem_rdata),
        .i_wdata      (r_wdata),
        .i_addr_lo    (r_addr_lo),
        .i_funct3     (r_funct3),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_INIT;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr_lo   <= 2'd0;
            r_wdata     <= 32'd0;
            r_mem_ren   <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= 32'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_state     <= w_state_next;
            r_mem_ren   <= w_mem_ren_next;
            r_mem_wen   <= w_mem_wen_next;
            r_done      <= w_done_next;
            r_err       <= w_err_next;
            r_rdata     <= w_rdata_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_cnt       <= (r_state == S_RD_WAIT) ? r_cnt + 1'b1 : '0;
            if (w_accept) begin
                r_we      <= i_we;
                r_funct3  <= i_funct3;
                r_addr_lo <= i_addr[1:0];
                r_wdata   <= i_wdata;
            end
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_INIT:  w_state_next = S_IDLE;
            S_IDLE: begin
                if (i_valid) begin
                    if (w_req_bad)                      w_state_next = S_RESP;
                    else if (i_we && i_funct3 == F3_W)  w_state_next = S_WRITE;
                    else                                w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: w_state_next = S_RD_WAIT;
            S_RD_WAIT: begin
                // A read that arrives on the final wait cycle still wins.
                if (i_mem_rvd)      w_state_next = r_we ? S_WRITE : S_RESP;
                else if (w_timeout) w_state_next = S_RESP;
            end
            S_WRITE: w_state_next = S_RESP;
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_INIT;
        endcase
    end

    // ---------------- outputs ----------------
    // Computes the value every registered output takes in the next state, so
    // each strobe is high for exactly the cycle spent in its state.
    always_comb begin
        w_mem_ren_next   = 1'b0;
        w_mem_wen_next   = 1'b0;
        w_done_next      = 1'b0;
        w_err_next       = 1'b0;
        w_rdata_next     = 32'd0;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    w_mem_addr_next = {i_addr[31:2], 2'b00};
                    if (w_req_bad) begin
                        w_done_next = 1'b1;
                        w_err_next  = 1'b1;
                    end else if (i_we && i_funct3 == F3_W) begin
                        w_mem_wen_next   = 1'b1;
                        w_mem_wdata_next = i_wdata;
                    end else begin
                        w_mem_ren_next = 1'b1;
                    end
                end
            end
            S_RD_WAIT: begin
                if (i_mem_rvd) begin
                    if (r_we) begin
                        w_mem_wen_next   = 1'b1;
                        w_mem_wdata_next = w_merge_data;
                    end else begin
                        w_done_next  = 1'b1;
                        w_rdata_next = w_load_data;
                    end
                end else if (w_timeout) begin
                    w_done_next = 1'b1;
                    w_err_next  = 1'b1;
                end
            end
            S_WRITE: w_done_next = 1'b1;
            default: ;
        endcase
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_rdata     = r_rdata;
    assign o_err       = r_err;
    assign o_mem_ren   = r_mem_ren;
    assign o_mem_wen   = r_mem_wen;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu
// Pairs dmem_lsu with a behavioural dmem (read data valid four cycles after the
// sampled read strobe) and checks each transaction against a byte-addressed
// reference memory.
// -----------------------------------------------------------------------------
module tb_dmem_lsu;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_err;
    logic        o_mem_ren;
    logic        o_mem_wen;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        mem_rvd;
    logic [31:0] mem_rdata;

    int vectors     = 0;
    int miscompares = 0;
    int tot_wen     = 0;

    always #5 clk = ~clk;

    dmem_lsu #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_we        (i_we),
        .i_funct3    (i_funct3),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_rdata     (o_rdata),
        .o_err       (o_err),
        .o_mem_ren   (o_mem_ren),
        .o_mem_wen   (o_mem_wen),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rvd   (mem_rvd),
        .i_mem_rdata (mem_rdata)
    );

    // ---------------- behavioural dmem ----------------
    logic [31:0] dmem_mem [0:63];
    logic [3:0]  rvd_pipe;
    logic [31:0] dat_pipe [0:3];
    logic        rvd_en;

    always @(posedge clk) begin
        if (rst) begin
            rvd_pipe <= 4'd0;
        end else begin
            rvd_pipe    <= {rvd_pipe[2:0], o_mem_ren};
            dat_pipe[0] <= dmem_mem[o_mem_addr[7:2]];
            dat_pipe[1] <= dat_pipe[0];
            dat_pipe[2] <= dat_pipe[1];
            dat_pipe[3] <= dat_pipe[2];
            if (o_mem_wen) dmem_mem[o_mem_addr[7:2]] <= o_mem_wdata;
        end
    end

    assign mem_rvd   = rvd_pipe[3] & rvd_en;
    assign mem_rdata = dat_pipe[3];

    always @(negedge clk) if (o_mem_wen) tot_wen++;

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [0:255];

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0] & 8'hFC;
        return {ref_mem[b + 8'd3], ref_mem[b + 8'd2], ref_mem[b + 8'd1], ref_mem[b]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int v;
        logic [7:0] b;
        b = a[7:0];
        case (f3)
            3'd0: begin v = $signed(ref_mem[b]);                   return v; end
            3'd1: begin v = $signed({ref_mem[b + 8'd1], ref_mem[b]}); return v; end
            3'd4: return {24'd0, ref_mem[b]};
            3'd5: return {16'd0, ref_mem[b + 8'd1], ref_mem[b]};
            default: return ref_word(a);
        endcase
    endfunction

    task automatic check(input string tag, input string what,
                         input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
        end
    endtask

    // One request, start to finish, checked against the reference model.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] obs_rdata);
        int size, exp_k, exp_ren_n, exp_wen_n, exp_wen_k;
        int got_k, ren_n, wen_n, ren_k, wen_k;
        bit legal, err_e, is_sw, tmo;
        logic [31:0] exp_rdata, exp_wword, base, ren_addr, wen_addr, wen_data;
        logic        got_err;

        size  = (int'(f3) % 4 == 0) ? 1 : (int'(f3) % 4 == 1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err_e = !legal || (int'(addr % 32'(size)) != 0);
        is_sw = we && (f3 == 3'd2);
        tmo   = !err_e && !is_sw && !rvd_en;
        base  = addr & ~32'd3;
        exp_wen_k = 0;
        if (err_e)      begin exp_k = 1;           exp_ren_n = 0; exp_wen_n = 0; end
        else if (is_sw) begin exp_k = 2;           exp_ren_n = 0; exp_wen_n = 1; exp_wen_k = 1; end
        else if (tmo)   begin exp_k = 2 + TIMEOUT; exp_ren_n = 1; exp_wen_n = 0; end
        else if (we)    begin exp_k = 7;           exp_ren_n = 1; exp_wen_n = 1; exp_wen_k = 6; end
        else            begin exp_k = 6;           exp_ren_n = 1; exp_wen_n = 0; end
        exp_rdata = (!we && !err_e && !tmo) ? ref_load(f3, addr) : 32'd0;
        exp_wword = 32'd0;
        if (we && !err_e && !tmo) begin
            for (int i = 0; i < size; i++) ref_mem[addr[7:0] + 8'(i)] = wd[i*8 +: 8];
            exp_wword = ref_word(addr);
        end

        @(negedge clk);
        for (int i = 0; i < 20 && o_busy; i++) @(negedge clk);
        i_valid = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wd;
        @(posedge clk);

        got_k = 0; ren_n = 0; wen_n = 0; ren_k = 0; wen_k = 0;
        ren_addr = 0; wen_addr = 0; wen_data = 0; got_err = 1'bx; obs_rdata = 32'hx;
        for (int k = 1; k <= TIMEOUT + 20; k++) begin
            @(negedge clk);
            if (o_mem_ren) begin ren_n++; ren_k = k; ren_addr = o_mem_addr; end
            if (o_mem_wen) begin wen_n++; wen_k = k; wen_addr = o_mem_addr; wen_data = o_mem_wdata; end
            if (o_done) begin got_k = k; got_err = o_err; obs_rdata = o_rdata; break; end
        end
        i_valid = 1'b0;

        $display("txn %s we=%0d f3=%0d addr=%h wd=%h -> rdata=%h err=%0d done@A+%0d ren=%0d wen=%0d",
                 tag, we, f3, addr, wd, obs_rdata, got_err, got_k, ren_n, wen_n);

        check(tag, "done_lat", 32'(got_k), 32'(exp_k));
        check(tag, "err", {31'd0, got_err}, {31'd0, err_e || tmo});
        check(tag, "rdata", obs_rdata, exp_rdata);
        check(tag, "ren_cnt", 32'(ren_n), 32'(exp_ren_n));
        check(tag, "wen_cnt", 32'(wen_n), 32'(exp_wen_n));
        if (exp_ren_n == 1 && ren_n == 1) begin
            check(tag, "ren_lat", 32'(ren_k), 32'd1);
            check(tag, "ren_addr", ren_addr, base);
        end
        if (exp_wen_n == 1 && wen_n == 1) begin
            check(tag, "wen_lat", 32'(wen_k), 32'(exp_wen_k));
            check(tag, "wen_addr", wen_addr, base);
            check(tag, "wen_data", wen_data, exp_wword);
        end
    endtask

    task automatic check_quiet(input string tag);
        check(tag, "ren", {31'd0, o_mem_ren}, 32'd0);
        check(tag, "wen", {31'd0, o_mem_wen}, 32'd0);
        check(tag, "done", {31'd0, o_done}, 32'd0);
        check(tag, "err", {31'd0, o_err}, 32'd0);
        check(tag, "rdata", o_rdata, 32'd0);
        check(tag, "mem_addr", o_mem_addr, 32'd0);
        check(tag, "mem_wdata", o_mem_wdata, 32'd0);
    endtask

    logic [31:0] rd;
    logic [31:0] w;
    int          wen_before;

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_we = 1'b0; i_funct3 = 3'd0;
        i_addr = 32'd0; i_wdata = 32'd0; rvd_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            w = (i == 4) ? 32'h8899AABB : (32'h01030507 * 32'(i + 1)) ^ 32'hA5C3_0000;
            dmem_mem[i] = w;
            for (int j = 0; j < 4; j++) ref_mem[i*4 + j] = w[j*8 +: 8];
        end

        // Reset state, then INIT lasts one cycle before IDLE.
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        @(negedge clk);
        check("post_reset", "busy", {31'd0, o_busy}, 32'd0);

        // Directed cases around mem[4] = 8899AABB.
        do_req("lw_10", 1'b0, 3'd2, 32'h10, 32'h0, rd);
        check("lw_10", "const", rd, 32'h8899AABB);
        do_req("lb_12", 1'b0, 3'd0, 32'h12, 32'h0, rd);
        check("lb_12", "const", rd, 32'hFFFFFF99);
        do_req("lbu_12", 1'b0, 3'd4, 32'h12, 32'h0, rd);
        check("lbu_12", "const", rd, 32'h00000099);
        do_req("lhu_12", 1'b0, 3'd5, 32'h12, 32'h0, rd);
        check("lhu_12", "const", rd, 32'h00008899);
        do_req("lh_12", 1'b0, 3'd1, 32'h12, 32'h0, rd);
        do_req("sb_11", 1'b1, 3'd0, 32'h11, 32'h55, rd);
        do_req("lw_10b", 1'b0, 3'd2, 32'h10, 32'h0, rd);
        check("lw_10b", "const", rd, 32'h889955BB);
        do_req("lh_11", 1'b0, 3'd1, 32'h11, 32'h0, rd);
        do_req("lw_12", 1'b0, 3'd2, 32'h12, 32'h0, rd);
        do_req("sw_13", 1'b1, 3'd2, 32'h13, 32'h12345678, rd);
        do_req("ld_f3_3", 1'b0, 3'd3, 32'h10, 32'h0, rd);
        do_req("st_f3_4", 1'b1, 3'd4, 32'h10, 32'h0, rd);
        do_req("sw_20", 1'b1, 3'd2, 32'h20, 32'hCAFEF00D, rd);
        do_req("sh_22", 1'b1, 3'd1, 32'h22, 32'hBEEF1234, rd);
        do_req("lw_20", 1'b0, 3'd2, 32'h20, 32'h0, rd);

        // dmem never answers: read times out, sub-word store writes nothing.
        rvd_en = 1'b0;
        do_req("tmo_lw", 1'b0, 3'd2, 32'h10, 32'h0, rd);
        do_req("tmo_sh", 1'b1, 3'd1, 32'h14, 32'h7777, rd);
        rvd_en = 1'b1;

        // Reset in the middle of an SH read phase: aborts with no write.
        @(negedge clk);
        wen_before = tot_wen;
        i_valid = 1'b1; i_we = 1'b1; i_funct3 = 3'd1; i_addr = 32'h1A; i_wdata = 32'hABCD;
        repeat (3) @(negedge clk);
        rst = 1'b1; i_valid = 1'b0;
        @(negedge clk);
        check_quiet("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_mid", "no_wen", 32'(tot_wen - wen_before), 32'd0);
        do_req("lw_18", 1'b0, 3'd2, 32'h18, 32'h0, rd);
        do_req("sh_1a", 1'b1, 3'd1, 32'h1A, 32'hABCD, rd);
        do_req("lw_18b", 1'b0, 3'd2, 32'h18, 32'h0, rd);

        // Randomized traffic over the first 16 words.
        for (int n = 0; n < 60; n++) begin
            do_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'($urandom_range(0, 63)), $urandom, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
